// File: rtl/spi_master_ctrl.sv
// SPI master frame controller: SS_n select, 3-bit op header, 8-bit payload and,
// for read-data frames, a turnaround cycle followed by an 8-bit MISO capture.
module spi_master_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StCmd,
        StPayload,
        StTurn,
        StRxd,
        StEnd
    } state_t;

    localparam logic [1:0] OpReadData = 2'b11;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [7:0] din_q, din_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic [2:0] pay_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            din_q   <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            din_q   <= din_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
        end
    end

    // cnt_q equals the frame cycle index n while SS_n is low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        din_d   = din_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    op_d    = op;
                    din_d   = din;
                    state_d = StSel;
                end
            end
            StSel: begin
                cnt_d   = cnt_q + 5'd1;
                state_d = StCmd;
            end
            StCmd: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd2) state_d = StPayload;
            end
            StPayload: begin
                if (cnt_q == 5'd10) begin
                    if (op_q == OpReadData) begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = StTurn;
                    end else begin
                        cnt_d   = '0;
                        state_d = StEnd;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StTurn: begin
                cnt_d   = cnt_q + 5'd1;
                state_d = StRxd;
            end
            StRxd: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 5'd19) begin
                    cnt_d   = '0;
                    dout_d  = {rx_q[6:0], MISO};
                    state_d = StEnd;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StEnd: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Serial outputs are decoded from the next state so they are registered
    // and aligned with the state they belong to.
    always_comb begin
        ss_n_d  = (state_d == StIdle) || (state_d == StEnd);
        mosi_d  = 1'b0;
        pay_idx = 3'(5'd10 - cnt_d);
        unique case (state_d)
            StSel:     mosi_d = op_d[1];
            StCmd:     mosi_d = (cnt_d == 5'd1) ? op_d[1] : op_d[0];
            StPayload: mosi_d = (op_d == OpReadData) ? 1'b1 : din_d[pay_idx];
            StTurn:    mosi_d = 1'b1;
            StRxd:     mosi_d = 1'b1;
            default:   mosi_d = 1'b0;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StEnd);
    assign dout = dout_q;
    assign SS_n = ss_n_q;
    assign MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural address/data memory slave.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int tests = 0;
    int fails = 0;

    spi_master_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .din  (din),
        .busy (busy),
        .done (done),
        .dout (dout),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: write-address/read-address set the pointer, write-data stores,
    // read-data returns mem[pointer] MSB first over n=12..19.
    logic [19:0] s_rx;
    int          s_n = 0;
    logic [7:0]  s_addr;
    logic [7:0]  s_mem [256];

    always @(posedge clk) begin
        if (!SS_n) begin
            s_rx <= {s_rx[18:0], MOSI};
            s_n  <= s_n + 1;
        end else if (s_n != 0) begin
            if (s_n == 11) begin
                case ({s_rx[9], s_rx[8]})
                    2'b00, 2'b10: s_addr <= s_rx[7:0];
                    2'b01:        s_mem[s_addr] <= s_rx[7:0];
                    default: ;
                endcase
            end
            s_n <= 0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] b;
        b = s_mem[s_addr];
        if (!SS_n && s_n >= 12 && s_n <= 19) MISO = b[19 - s_n];
        else MISO = 1'b0;
    end

    task automatic run_frame(input logic [1:0] f_op, input logic [7:0] f_din, input int inj_at,
                             output logic [19:0] bits, output int ss_low, output int busy_cnt,
                             output int done_cnt, output logic [7:0] dout_done);
        bits      = '0;
        ss_low    = 0;
        busy_cnt  = 0;
        done_cnt  = 0;
        dout_done = '0;
        @(negedge clk);
        start = 1'b1;
        op    = f_op;
        din   = f_din;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!SS_n) begin
                bits = {bits[18:0], MOSI};
                ss_low++;
                if (ss_low - 1 == inj_at) begin
                    start = 1'b1;
                    op    = 2'b11;
                    din   = 8'hFF;
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                dout_done = dout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL reset_ss_n: got %b expected 1", SS_n); end
        tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", dout); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_addr();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        run_frame(2'b00, 8'd100, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        tests++; if (bits[10:0] !== 11'b00001100100) begin fails++; $display("FAIL wa_mosi: got %b expected 00001100100", bits[10:0]); end
        tests++; if (ss_low !== 11) begin fails++; $display("FAIL wa_ss_low: got %0d expected 11", ss_low); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL wa_done: got %0d expected 1", done_cnt); end
        tests++; if (dd !== 8'h00) begin fails++; $display("FAIL wa_dout: got %h expected 00", dd); end
        @(negedge clk);
        tests++; if (SS_n !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL wa_idle: got ss_n=%b busy=%b expected 1 0", SS_n, busy);
        end
    endtask

    task automatic test_write_data();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        run_frame(2'b01, 8'd11, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        tests++; if (bits[10:0] !== 11'b00100001011) begin fails++; $display("FAIL wd_mosi: got %b expected 00100001011", bits[10:0]); end
        tests++; if (busy_cnt !== 12) begin fails++; $display("FAIL wd_busy: got %0d expected 12", busy_cnt); end
        tests++; if (ss_low !== 11) begin fails++; $display("FAIL wd_ss_low: got %0d expected 11", ss_low); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL wd_done: got %0d expected 1", done_cnt); end
    endtask

    // Slave pointer is 100 and mem[100] holds 8'h0B from the two frames above.
    task automatic test_read_data();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        run_frame(2'b11, 8'h00, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        tests++; if (bits !== 20'hFFFFF) begin fails++; $display("FAIL rd_mosi: got %h expected fffff", bits); end
        tests++; if (ss_low !== 20) begin fails++; $display("FAIL rd_ss_low: got %0d expected 20", ss_low); end
        tests++; if (dd !== 8'h0B) begin fails++; $display("FAIL rd_dout: got %h expected 0b", dd); end
        tests++; if (busy_cnt !== 21) begin fails++; $display("FAIL rd_busy: got %0d expected 21", busy_cnt); end
        @(negedge clk);
        tests++; if (dout !== 8'h0B) begin fails++; $display("FAIL rd_dout_hold: got %h expected 0b", dout); end
    endtask

    task automatic test_loopback();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        logic [7:0] ref_val;
        for (int i = 0; i < 100; i++) begin
            ref_val = 8'(11 * ((i % 23) + 1));
            run_frame(2'b00, 8'(100 + i), -1, bits, ss_low, busy_cnt, done_cnt, dd);
            run_frame(2'b01, ref_val, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        end
        for (int i = 0; i < 100; i++) begin
            ref_val = 8'(11 * ((i % 23) + 1));
            run_frame(2'b10, 8'(100 + i), -1, bits, ss_low, busy_cnt, done_cnt, dd);
            run_frame(2'b11, 8'h00, -1, bits, ss_low, busy_cnt, done_cnt, dd);
            tests++; if (dd !== ref_val) begin
                fails++; $display("FAIL loopback_%0d: got %h expected %h", 100 + i, dd, ref_val);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        int extra_done, extra_low;
        run_frame(2'b00, 8'hA5, 5, bits, ss_low, busy_cnt, done_cnt, dd);
        tests++; if (bits[10:0] !== 11'b00010100101) begin fails++; $display("FAIL swb_mosi: got %b expected 00010100101", bits[10:0]); end
        tests++; if (ss_low !== 11) begin fails++; $display("FAIL swb_ss_low: got %0d expected 11", ss_low); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL swb_done: got %0d expected 1", done_cnt); end
        extra_done = 0;
        extra_low  = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) extra_done++;
            if (!SS_n) extra_low++;
        end
        tests++; if (extra_done !== 0 || extra_low !== 0) begin
            fails++; $display("FAIL swb_no_queue: got done=%0d low=%0d expected 0 0", extra_done, extra_low);
        end
    endtask

    task automatic test_reset_abort();
        logic [19:0] bits;
        int ss_low, busy_cnt, done_cnt;
        logic [7:0] dd;
        int n, rst_done;
        bit hit;
        run_frame(2'b00, 8'h20, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        run_frame(2'b01, 8'h5A, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        din   = 8'h00;
        n     = 0;
        hit   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!SS_n) begin
                if (n == 7) begin
                    hit = 1'b1;
                    break;
                end
                n++;
            end
        end
        tests++; if (!hit) begin fails++; $display("FAIL abort_reach_n7: got n=%0d expected 7", n); end
        rst_n = 1'b0;
        #1;
        tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL abort_ss_n: got %b expected 1", SS_n); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL abort_dout: got %h expected 00", dout); end
        tests++; if (busy !== 1'b0 || MOSI !== 1'b0) begin
            fails++; $display("FAIL abort_busy_mosi: got %b %b expected 0 0", busy, MOSI);
        end
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) rst_done++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) rst_done++;
        end
        tests++; if (rst_done !== 0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", rst_done); end
        run_frame(2'b11, 8'h00, -1, bits, ss_low, busy_cnt, done_cnt, dd);
        tests++; if (bits !== 20'hFFFFF) begin fails++; $display("FAIL post_abort_mosi: got %h expected fffff", bits); end
        tests++; if (ss_low !== 20) begin fails++; $display("FAIL post_abort_ss_low: got %0d expected 20", ss_low); end
        tests++; if (done_cnt !== 1 || dd !== 8'h5A) begin
            fails++; $display("FAIL post_abort_read: got done=%0d dout=%h expected 1 5a", done_cnt, dd);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_data();
        test_loopback();
        test_start_while_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
